seg_display_shifter: RTL and testbench

// - Responder end of the segment command interface (seg_data/off/shift/write/clear) driven by the scrolling controller.
// - Holds a NUM_DIGITS-deep digit buffer and applies shift/write/clear commands to it.
// - Time-multiplexes the buffer onto a common-anode 7-segment bank through a hex decoder, with ghost blanking.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_hex_decoder.sv | 23 ++
 rtl/seg_display_shifter.sv | 122 ++++++++++++
 tb/tb_seg_display_shifter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and constants for the 7-segment display shifter:
//               buffer entry type, blank pattern, hex decode table, scan states.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef struct packed {
        logic       off;
        logic [3:0] data;
    } seg_entry_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, index 15 (F) first.
    localparam logic [15:0][6:0] SEG_HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [0:0] {
        GHOST = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decoder
// Description : Combinational buffer-entry to active-low segment pattern;
//               blanked entries yield the all-dark pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decoder
    import seg_pkg::*;
(
    input  seg_entry_t entry,
    output logic [6:0] seg_cat
);

    always_comb begin
        seg_cat = SEG_BLANK;
        if (!entry.off) begin
            seg_cat = SEG_HEX_TABLE[entry.data];
        end
    end

endmodule : seg_hex_decoder
`default_nettype wire

// File: rtl/seg_display_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_shifter
// Description : Digit buffer with shift/write/clear commands, multiplexed onto
//               a common-anode 7-segment bank with ghost blanking per slot.
//               Optional PWM dimming enabled by defining SEG_DIM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_shifter
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int GHOST_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            seg_data,
    input  logic                  seg_off,
    input  logic                  seg_shift,
    input  logic                  seg_write,
    input  logic                  seg_clear,
`ifdef SEG_DIM_EN
    input  logic [2:0]            brightness,
`endif
    output logic [NUM_DIGITS-1:0] seg_an,
    output logic [6:0]            seg_cat
);

    localparam int c_presc_w = $clog2(REFRESH_DIV);
    localparam int c_idx_w   = $clog2(NUM_DIGITS);

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(REFRESH_DIV - 1);
    localparam logic [c_presc_w-1:0] c_ghost_end  = c_presc_w'(GHOST_CYCLES);
    localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(NUM_DIGITS - 1);

    seg_entry_t            r_buf [NUM_DIGITS];
    logic [c_presc_w-1:0]  r_presc;
    logic [c_idx_w-1:0]    r_idx;
    scan_state_t           r_state;

    logic [c_presc_w-1:0]  w_presc_next;
    logic                  w_wrap;
    logic [6:0]            w_dec_cat;
    logic                  w_pwm_on;
    seg_entry_t            w_new_entry;

    assign w_wrap       = (r_presc == c_presc_last);
    assign w_presc_next = w_wrap ? '0 : r_presc + 1'b1;
    assign w_new_entry  = '{off: seg_off, data: seg_data};

    // Digit buffer: clear dominates any concurrent write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_buf[i] <= '{off: 1'b1, data: 4'h0};
            end
        end else if (seg_clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_buf[i] <= '{off: 1'b1, data: 4'h0};
            end
        end else if (seg_write) begin
            if (seg_shift) begin
                for (int i = 1; i < NUM_DIGITS; i++) begin
                    r_buf[i] <= r_buf[i-1];
                end
            end
            r_buf[0] <= w_new_entry;
        end
    end

    // Scan FSM: the state always tracks whether the prescaler is in the ghost window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_state <= GHOST;
        end else begin
            r_presc <= w_presc_next;
            if (w_wrap) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end
            r_state <= (w_presc_next < c_ghost_end) ? GHOST : DRIVE;
        end
    end

`ifdef SEG_DIM_EN
    logic [2:0] r_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 3'd1;
        end
    end

    assign w_pwm_on = (r_pwm <= brightness);
`else
    assign w_pwm_on = 1'b1;
`endif

    seg_hex_decoder u_dec (
        .entry   (r_buf[r_idx]),
        .seg_cat (w_dec_cat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_an  <= '1;
            seg_cat <= SEG_BLANK;
        end else if (r_state == DRIVE) begin
            seg_an  <= w_pwm_on ? ~(NUM_DIGITS'(1) << r_idx) : '1;
            seg_cat <= w_dec_cat;
        end else begin
            seg_an  <= '1;
            seg_cat <= SEG_BLANK;
        end
    end

endmodule : seg_display_shifter
`default_nettype wire

// File: tb/tb_seg_display_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_shifter
// Description : Self-checking bench; a cycle-count based display model predicts
//               seg_an/seg_cat every cycle under directed and random commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_shifter;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    seg_data;
    logic          seg_off;
    logic          seg_shift;
    logic          seg_write;
    logic          seg_clear;
    logic [2:0]    brightness;
    logic [ND-1:0] seg_an;
    logic [6:0]    seg_cat;

    int tests = 0;
    int fails = 0;

    // Model: each entry is {off, data}; cyc counts edges since reset release.
    logic [4:0]  mbuf [ND];
    int unsigned cyc;

    always #5 clk = ~clk;

    seg_display_shifter #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .GHOST_CYCLES (GC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_data  (seg_data),
        .seg_off   (seg_off),
        .seg_shift (seg_shift),
        .seg_write (seg_write),
        .seg_clear (seg_clear),
`ifdef SEG_DIM_EN
        .brightness(brightness),
`endif
        .seg_an    (seg_an),
        .seg_cat   (seg_cat)
    );

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) mbuf[i] = 5'h10;
        cyc = 0;
    endtask

    // One clock: predict the output register from the pre-edge model, then apply the command.
    task automatic step(input logic wr, input logic sh, input logic off, input logic clr,
                        input logic [3:0] d);
        int unsigned phase, slot;
        logic [ND-1:0] exp_an;
        logic [6:0]    exp_cat;
        seg_write = wr; seg_shift = sh; seg_off = off; seg_clear = clr; seg_data = d;
        phase = cyc % RD;
        slot  = (cyc / RD) % ND;
        if (phase < GC) begin
            exp_an  = '1;
            exp_cat = 7'h7F;
        end else begin
            exp_an  = ((cyc % 8) <= brightness) ? ~(ND'(1) << slot) : '1;
            exp_cat = mbuf[slot][4] ? 7'h7F : hex7(mbuf[slot][3:0]);
        end
        @(posedge clk);
        #1;
        check("seg_an", 32'(seg_an), 32'(exp_an));
        check("seg_cat", 32'(seg_cat), 32'(exp_cat));
        if (clr) begin
            for (int i = 0; i < ND; i++) mbuf[i] = 5'h10;
        end else if (wr) begin
            if (sh) begin
                for (int i = ND - 1; i > 0; i--) mbuf[i] = mbuf[i-1];
            end
            mbuf[0] = {off, d};
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        rst = 1'b1; brightness = 3'd7;
        seg_data = '0; seg_off = 1'b0; seg_shift = 1'b0; seg_write = 1'b0; seg_clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_an", 32'(seg_an), 32'hF);
        check("reset_cat", 32'(seg_cat), 32'h7F);
        rst = 1'b0;

        idle(40);
        // Shift-writes 1..4, then a full scan.
        for (int v = 1; v <= 4; v++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'(v));
        idle(32);
        // Fifth shift-write pushes the leading 1 out.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        idle(32);
        // Clear beats a concurrent write.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h9);
        idle(32);
        for (int v = 5; v <= 8; v++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'(v));
        // Shift without write does nothing.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'hA);
        // Overwrite digit 0 inside its DRIVE window.
        while ((cyc % (RD * ND)) != 2) idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
        idle(1);
        check("overwrite_F", 32'(seg_cat), 32'h0E);
        idle(32);

        // Randomized commands.
        for (int i = 0; i < 400; i++) begin
`ifdef SEG_DIM_EN
            if ($urandom_range(0, 31) == 0) brightness = 3'($urandom_range(0, 7));
`endif
            step(($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 24) == 0), 4'($urandom));
        end

`ifdef SEG_DIM_EN
        brightness = 3'd1;
        idle(64);
        brightness = 3'd7;
`endif

        // Asynchronous reset in the middle of a DRIVE window.
        while ((cyc % RD) != 4) idle(1);
        rst = 1'b1;
        #1;
        check("async_rst_an", 32'(seg_an), 32'hF);
        check("async_rst_cat", 32'(seg_cat), 32'h7F);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $error("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_seg_display_shifter
`default_nettype wire
